// File: rtl/nco_pkg.sv
// nco_pkg: constants and helpers shared by the nco_pipe NCO.
//   ATAN_TBL     : CORDIC arctangents as 32-bit binary angles (circle = 2^32),
//                  truncated to the phase width at the point of use.
//   INV_GAIN_Q16 : 1/K CORDIC gain compensation in Q16.
//   MAX_STG      : largest supported number of rotation stages.
//   LFSR_SEED/LFSR_TAPS : dither generator settings (used with NCO_DITHER_EN).
package nco_pkg;

  localparam int MAX_STG      = 16;
  localparam int INV_GAIN_Q16 = 39797;

  // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [31:0] ATAN_TBL [0:15] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861
  };

  // Start amplitude: full scale (with 2 guard bits) pre-divided by the CORDIC gain
  function automatic int x0_init(input int ow);
    longint prod;
    prod = ((64'sd1 <<< (ow - 1)) - 64'sd1) * 64'sd4 * 64'(INV_GAIN_Q16);
    return int'(prod >>> 16);
  endfunction

endpackage

// File: rtl/nco_pipe_if.sv
// nco_pipe_if: control / sample bus of the nco_pipe NCO.
//   En   : advance accumulator and launch one sample
//   Clr  : synchronous accumulator clear (priority over En)
//   FCW  : frequency control word, POFF : per-sample phase offset
//   Vld, Cos, Sin : output sample and its valid flag
// master = sample consumer/controller side, slave = the NCO.
interface nco_pipe_if #(
  parameter int PW = 20,
  parameter int OW = 12
);
  logic                 En;
  logic                 Clr;
  logic [PW-1:0]        FCW;
  logic [PW-1:0]        POFF;
  logic                 Vld;
  logic signed [OW-1:0] Cos;
  logic signed [OW-1:0] Sin;

  modport master (output En, Clr, FCW, POFF, input Vld, Cos, Sin);
  modport slave  (input En, Clr, FCW, POFF, output Vld, Cos, Sin);
endinterface

// File: rtl/cordic_rot_stage.sv
// cordic_rot_stage: one registered CORDIC rotation step.
//   Parameters: IW data width, ZW residual-angle width (phase width - 1),
//   SHIFT stage index (also selects the arctangent).
//   Ports: clk, rst (async, active high); v/q side-band and x/y/z data in,
//   registered v/q/x/y/z out.
module cordic_rot_stage
  import nco_pkg::*;
#(
  parameter int IW    = 14,
  parameter int ZW    = 19,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 v_in,
  input  logic [1:0]           q_in,
  input  logic signed [IW-1:0] x_in,
  input  logic signed [IW-1:0] y_in,
  input  logic signed [ZW-1:0] z_in,
  output logic                 v_out,
  output logic [1:0]           q_out,
  output logic signed [IW-1:0] x_out,
  output logic signed [IW-1:0] y_out,
  output logic signed [ZW-1:0] z_out
);
  // Phase width is ZW+1, so a 32-bit angle drops 31-ZW bits
  localparam logic [31:0]          ATAN_FULL = ATAN_TBL[SHIFT];
  localparam logic signed [ZW-1:0] ATAN      = ZW'(ATAN_FULL >> (31 - ZW));

  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] ys;

  assign xs = x_in >>> SHIFT;
  assign ys = y_in >>> SHIFT;

  // Rotate towards zero residual angle; side-band travels with the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_out <= 1'b0;
      q_out <= 2'd0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      v_out <= v_in;
      q_out <= q_in;
      if (!z_in[ZW-1]) begin
        x_out <= x_in - ys;
        y_out <= y_in + xs;
        z_out <= z_in - ATAN;
      end else begin
        x_out <= x_in + ys;
        y_out <= y_in - xs;
        z_out <= z_in + ATAN;
      end
    end
  end

endmodule

// File: rtl/nco_pipe.sv
// nco_pipe: pipelined CORDIC numerically controlled oscillator.
//   Phase accumulator -> phase register -> quadrant fold / prep register ->
//   NUM_STG rotation stages -> unfold, round, saturate -> Cos/Sin register.
//   A launch at edge k shows up with Vld=1 after edge k+NUM_STG+2.
//   Ports: clk, rst (async, active high), bus (nco_pipe_if.slave).
//   Optional: define NCO_DITHER_EN to add 4-bit LFSR phase dither.
module nco_pipe
  import nco_pkg::*;
#(
  parameter int PW      = 20,
  parameter int OW      = 12,
  parameter int NUM_STG = 10
) (
  input logic       clk,
  input logic       rst,
  nco_pipe_if.slave bus
);
  localparam int IW = OW + 2;
  localparam int ZW = PW - 1;
  localparam int EW = IW + 1;
  localparam int NS = (NUM_STG > MAX_STG) ? MAX_STG : ((NUM_STG < 1) ? 1 : NUM_STG);

  localparam logic signed [IW-1:0] X0     = IW'(x0_init(OW));
  localparam logic signed [EW-1:0] HALF   = EW'(2);
  localparam logic signed [EW-1:0] SAT_HI = EW'((2 ** (OW - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_LO = -SAT_HI;

  // Round half up by 4, then clip symmetrically so -2^(OW-1) never appears
  function automatic logic signed [OW-1:0] round_sat(input logic signed [EW-1:0] v);
    logic signed [EW-1:0] r;
    r = (v + HALF) >>> 2;
    if (r > SAT_HI)      return SAT_HI[OW-1:0];
    else if (r < SAT_LO) return SAT_LO[OW-1:0];
    else                 return r[OW-1:0];
  endfunction

  logic [PW-1:0] acc;
  logic [PW-1:0] acc_next;
  logic [PW-1:0] phase;
  logic [PW-1:0] ph;
  logic          ph_vld;

  // Next accumulator value; Clr wins over En
  always_comb begin
    acc_next = acc;
    if (bus.Clr)     acc_next = '0;
    else if (bus.En) acc_next = acc + bus.FCW;
    else             acc_next = acc;
  end

`ifdef NCO_DITHER_EN
  logic [15:0]   lfsr;
  logic [PW-1:0] dith;

  // Low nibble taken as a signed value in [-8,7]
  assign dith = {{(PW-4){lfsr[3]}}, lfsr[3:0]};

  // Dither generator steps only when a sample is launched
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lfsr <= LFSR_SEED;
    else if (bus.En) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign phase = acc_next + bus.POFF + dith;
`else
  assign phase = acc_next + bus.POFF;
`endif

  // Accumulator and launched-phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      ph     <= '0;
      ph_vld <= 1'b0;
    end else begin
      acc    <= acc_next;
      ph_vld <= bus.En;
      if (bus.En) ph <= phase;
    end
  end

  logic                 v_pipe [0:NS];
  logic [1:0]           q_pipe [0:NS];
  logic signed [IW-1:0] x_pipe [0:NS];
  logic signed [IW-1:0] y_pipe [0:NS];
  logic signed [ZW-1:0] z_pipe [0:NS];

  logic                 prep_v;
  logic [1:0]           prep_q;
  logic signed [ZW-1:0] prep_z;

  // Fold phase into the first quadrant; the quadrant rides along for the unfold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prep_v <= 1'b0;
      prep_q <= 2'd0;
      prep_z <= '0;
    end else begin
      prep_v <= ph_vld;
      prep_q <= ph[PW-1:PW-2];
      prep_z <= {1'b0, ph[PW-3:0]};
    end
  end

  assign v_pipe[0] = prep_v;
  assign q_pipe[0] = prep_q;
  assign x_pipe[0] = X0;
  assign y_pipe[0] = '0;
  assign z_pipe[0] = prep_z;

  genvar g;
  generate
    for (g = 0; g < NS; g++) begin : g_stg
      cordic_rot_stage #(
        .IW   (IW),
        .ZW   (ZW),
        .SHIFT(g)
      ) u_stg (
        .clk  (clk),
        .rst  (rst),
        .v_in (v_pipe[g]),
        .q_in (q_pipe[g]),
        .x_in (x_pipe[g]),
        .y_in (y_pipe[g]),
        .z_in (z_pipe[g]),
        .v_out(v_pipe[g+1]),
        .q_out(q_pipe[g+1]),
        .x_out(x_pipe[g+1]),
        .y_out(y_pipe[g+1]),
        .z_out(z_pipe[g+1])
      );
    end
  endgenerate

  logic signed [EW-1:0] xe;
  logic signed [EW-1:0] ye;
  logic signed [EW-1:0] ux;
  logic signed [EW-1:0] uy;

  // One extra bit so negating the rotator output cannot overflow
  assign xe = {x_pipe[NS][IW-1], x_pipe[NS]};
  assign ye = {y_pipe[NS][IW-1], y_pipe[NS]};

  // Rotate the first-quadrant result back into its original quadrant
  always_comb begin
    ux = xe;
    uy = ye;
    case (q_pipe[NS])
      2'd0:    begin ux = xe;  uy = ye;  end
      2'd1:    begin ux = -ye; uy = xe;  end
      2'd2:    begin ux = -xe; uy = -ye; end
      2'd3:    begin ux = ye;  uy = -xe; end
      default: begin ux = xe;  uy = ye;  end
    endcase
  end

  // Output register; Cos/Sin hold their last valid sample while Vld=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Vld <= 1'b0;
      bus.Cos <= '0;
      bus.Sin <= '0;
    end else begin
      bus.Vld <= v_pipe[NS];
      if (v_pipe[NS]) begin
        bus.Cos <= round_sat(ux);
        bus.Sin <= round_sat(uy);
      end
    end
  end

endmodule
